// File: rtl/jtframe_db15_pkg.sv
// ---------------------------------------------------------------------------
// jtframe_db15_pkg
// Shared constants and types for the DB15 joystick adapter transmitter.
//   DB15_W          : bits per player word
//   DB15_UP..COIN   : bit positions of each control inside a player word
//   db15_state_e    : transmitter frame states
//   db15_cnt_w()    : width of a counter able to hold 0..2*w
// ---------------------------------------------------------------------------
package jtframe_db15_pkg;

    localparam int DB15_W     = 12;

    localparam int DB15_UP    = 0;
    localparam int DB15_DOWN  = 1;
    localparam int DB15_LEFT  = 2;
    localparam int DB15_RIGHT = 3;
    localparam int DB15_B1    = 4;
    localparam int DB15_B2    = 5;
    localparam int DB15_B3    = 6;
    localparam int DB15_B4    = 7;
    localparam int DB15_B5    = 8;
    localparam int DB15_B6    = 9;
    localparam int DB15_START = 10;
    localparam int DB15_COIN  = 11;

    typedef enum logic [1:0] {
        ST_LOAD      = 2'd0,
        ST_SHIFT     = 2'd1,
        ST_IDLE_TAIL = 2'd2
    } db15_state_e;

    // Counter must reach 2*w without wrapping.
    function automatic int db15_cnt_w(input int w);
        return $clog2(2 * w + 1);
    endfunction

endpackage

// File: rtl/jtframe_db15_sync.sv
// ---------------------------------------------------------------------------
// jtframe_db15_sync
// Brings one asynchronous reader line into the clk domain and flags its
// rising edges.
//   clk, rst   : block clock, asynchronous active-high reset
//   din        : raw asynchronous line (idles high)
//   level      : synchronized line level (last synchronizer stage)
//   rise       : one-cycle pulse on an accepted rising edge
// Parameters:
//   SYNC       : synchronizer depth, must be 2 or more
//   DEGLITCH   : 1 = an edge is accepted only after one low cycle followed
//                by two consecutive high cycles (single-cycle highs are
//                ignored, one extra cycle of latency). The top selects this
//                for the shift clock through JTFRAME_DB15_TX_DEGLITCH_EN.
// ---------------------------------------------------------------------------
module jtframe_db15_sync #(
    parameter int SYNC     = 2,
    parameter bit DEGLITCH = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [SYNC-1:0] sync_q;
    logic            prev_q;

    // Flops reset to 1 so an idle-high line never produces a spurious edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC-2:0], din};
            prev_q <= sync_q[SYNC-1];
        end
    end

    assign level = sync_q[SYNC-1];

    generate
        if (DEGLITCH) begin : g_deglitch
            logic prev2_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    prev2_q <= 1'b1;
                end else begin
                    prev2_q <= prev_q;
                end
            end

            // Pattern low, high, high (oldest to newest).
            assign rise = level & prev_q & ~prev2_q;
        end else begin : g_plain
            assign rise = level & ~prev_q;
        end
    endgenerate

endmodule

// File: rtl/jtframe_db15_tx.sv
// ---------------------------------------------------------------------------
// jtframe_db15_tx
// Device side of the DB15 joystick adapter: a 74x165-style parallel-load
// shift chain that answers a reader driving joy_load / joy_clk.
//   clk, rst    : block clock (>= 4x joy_clk toggle rate), async active-high
//                 reset
//   joy1, joy2  : player button words, active high (1 = pressed)
//   joy_load    : reader load strobe, active low, asynchronous
//   joy_clk     : reader shift clock, asynchronous
//   joy_data    : serial data, active low; order joy1[0..W-1], joy2[0..W-1]
//   frame_done  : one-cycle pulse when the counter reaches 2*W
//   overrun     : sticky flag for shifts past 2*W, cleared by the next load
// Build option:
//   JTFRAME_DB15_TX_DEGLITCH_EN : deglitch the synchronized joy_clk so that
//                 single-cycle high pulses are not taken as shift edges.
// ---------------------------------------------------------------------------
module jtframe_db15_tx
    import jtframe_db15_pkg::*;
#(
    parameter int W    = DB15_W,
    parameter int SYNC = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] joy1,
    input  logic [W-1:0] joy2,
    input  logic         joy_load,
    input  logic         joy_clk,
    output logic         joy_data,
    output logic         frame_done,
    output logic         overrun
);

    localparam int            CW    = db15_cnt_w(W);
    localparam logic [CW-1:0] TOTAL = CW'(2 * W);
    localparam logic [CW-1:0] LAST  = CW'(2 * W - 1);

`ifdef JTFRAME_DB15_TX_DEGLITCH_EN
    localparam bit CLK_DEGLITCH = 1'b1;
`else
    localparam bit CLK_DEGLITCH = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Line synchronizers
    // ---------------------------------------------------------------
    logic load_lvl;
    logic load_rise;
    logic unused_clk_lvl;
    logic clk_rise;

    jtframe_db15_sync #(
        .SYNC     (SYNC),
        .DEGLITCH (1'b0)
    ) u_sync_load (
        .clk   (clk),
        .rst   (rst),
        .din   (joy_load),
        .level (load_lvl),
        .rise  (load_rise)
    );

    jtframe_db15_sync #(
        .SYNC     (SYNC),
        .DEGLITCH (CLK_DEGLITCH)
    ) u_sync_clk (
        .clk   (clk),
        .rst   (rst),
        .din   (joy_clk),
        .level (unused_clk_lvl),
        .rise  (clk_rise)
    );

    // ---------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------
    db15_state_e     state_q, state_d;
    db15_state_e     cur_state;
    logic [2*W-1:0]  shreg_q, shreg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovr_q, ovr_d;
    logic            done_q, done_d;

    // Reset parks in IDLE_TAIL: with no load seen yet there is no frame to
    // send, so any stray shift edge is treated as excess.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE_TAIL;
            shreg_q <= '1;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
            done_q  <= done_d;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // cur_state is the state in force this cycle: a low synced load
    // overrides everything (so load beats a coincident shift edge), and
    // the release of load starts the frame in the same cycle.
    // ---------------------------------------------------------------
    always_comb begin
        cur_state = state_q;
        if (!load_lvl) begin
            cur_state = ST_LOAD;
        end else if (load_rise) begin
            cur_state = ST_SHIFT;
        end

        state_d = cur_state;
        if (cur_state == ST_SHIFT && clk_rise && cnt_q == LAST) begin
            state_d = ST_IDLE_TAIL;
        end
    end

    // ---------------------------------------------------------------
    // Output / datapath logic
    // ---------------------------------------------------------------
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;
        done_d  = 1'b0;

        unique case (cur_state)
            ST_LOAD: begin
                // Bit 0 is the first one presented on joy_data.
                shreg_d = ~{joy2, joy1};
                cnt_d   = '0;
                ovr_d   = 1'b0;
            end
            ST_SHIFT: begin
                if (clk_rise) begin
                    shreg_d = {1'b1, shreg_q[2*W-1:1]};
                    cnt_d   = cnt_q + 1'b1;
                    done_d  = (cnt_q == LAST);
                end
            end
            ST_IDLE_TAIL: begin
                if (clk_rise) begin
                    shreg_d = {1'b1, shreg_q[2*W-1:1]};
                    cnt_d   = TOTAL;
                    ovr_d   = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // After 2*W shifts every bit has been replaced by a released 1, so the
    // output bit alone already yields 1 in IDLE_TAIL.
    assign joy_data   = shreg_q[0];
    assign frame_done = done_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_jtframe_db15_tx.sv
// ---------------------------------------------------------------------------
// tb_jtframe_db15_tx
// Directed bench for jtframe_db15_tx: acts as the serial reader, collects
// the serial stream bit by bit and compares against hand-computed frames.
// ---------------------------------------------------------------------------
module tb_jtframe_db15_tx;

    localparam int W = 12;

    logic         clk;
    logic         rst;
    logic [W-1:0] joy1;
    logic [W-1:0] joy2;
    logic         joy_load;
    logic         joy_clk;
    logic         joy_data;
    logic         frame_done;
    logic         overrun;

    int n_checks;
    int n_pass;

    jtframe_db15_tx #(
        .W    (W),
        .SYNC (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .joy1       (joy1),
        .joy2       (joy2),
        .joy_load   (joy_load),
        .joy_clk    (joy_clk),
        .joy_data   (joy_data),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Load strobe low for 5 cycles, then released and allowed to settle.
    task automatic do_load(input logic [W-1:0] p1, input logic [W-1:0] p2);
        joy1     = p1;
        joy2     = p2;
        joy_load = 1'b0;
        repeat (5) @(negedge clk);
        joy_load = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    // One full shift clock period (low then high); reports a frame_done seen.
    task automatic clk_edge(output logic saw_done);
        saw_done = 1'b0;
        joy_clk  = 1'b0;
        repeat (5) begin
            @(negedge clk);
            saw_done = saw_done | frame_done;
        end
        joy_clk = 1'b1;
        repeat (5) begin
            @(negedge clk);
            saw_done = saw_done | frame_done;
        end
    endtask

    // Sample the line before each edge; stream bits past n stay 1.
    task automatic run_edges(input string name, input int n, output logic [31:0] stream,
                             output int done_edge, output int done_cnt);
        logic saw;
        stream    = '1;
        done_edge = 0;
        done_cnt  = 0;
        for (int k = 0; k < n; k++) begin
            stream[k] = joy_data;
            clk_edge(saw);
            if (saw) begin
                done_cnt++;
                done_edge = k + 1;
            end
        end
        $display("xfer %s: edges=%0d stream=%h done_edge=%0d done_cnt=%0d ovr=%b",
                 name, n, stream, done_edge, done_cnt, overrun);
    endtask

    initial begin
        logic [31:0] stream;
        int          done_edge;
        int          done_cnt;
        int          bad_data;
        int          bad_done;
        int          bad_ovr;

        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        joy1     = '0;
        joy2     = '0;
        joy_load = 1'b1;
        joy_clk  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset
        bad_data = 0;
        bad_done = 0;
        bad_ovr  = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (joy_data !== 1'b1)   bad_data++;
            if (frame_done !== 1'b0) bad_done++;
            if (overrun !== 1'b0)    bad_ovr++;
        end
        check("idle_data", bad_data, 0);
        check("idle_done", bad_done, 0);
        check("idle_ovr", bad_ovr, 0);

        // Frame A: joy1[0] and joy2[11] pressed
        do_load(12'h001, 12'h800);
        check("a_load_bit0", {31'd0, joy_data}, 32'd0);
        run_edges("frame_a", 24, stream, done_edge, done_cnt);
        check("a_stream", stream, 32'hFF7F_FFFE);
        check("a_done_edge", done_edge, 24);
        check("a_done_cnt", done_cnt, 1);
        check("a_ovr_clear", {31'd0, overrun}, 32'd0);

        // Three excess edges
        run_edges("tail_a", 3, stream, done_edge, done_cnt);
        check("tail_stream", stream, 32'hFFFF_FFFF);
        check("tail_data", {31'd0, joy_data}, 32'd1);
        check("tail_done_cnt", done_cnt, 0);
        check("tail_ovr", {31'd0, overrun}, 32'd1);

        // New load clears overrun; frame contents frozen against joy1 change
        do_load(12'h000, 12'h000);
        check("reload_ovr", {31'd0, overrun}, 32'd0);
        run_edges("freeze_1", 5, stream, done_edge, done_cnt);
        joy1 = 12'hFFF;
        check("freeze_head", stream, 32'hFFFF_FFFF);
        run_edges("freeze_2", 19, stream, done_edge, done_cnt);
        check("freeze_stream", stream, 32'hFFFF_FFFF);
        check("freeze_done_cnt", done_cnt, 1);

        // Reset mid-frame after edge 10
        do_load(12'hFFF, 12'h000);
        run_edges("pre_rst", 10, stream, done_edge, done_cnt);
        check("pre_rst_stream", stream, 32'hFFFF_FC00);
        check("pre_rst_data", {31'd0, joy_data}, 32'd0);
        rst = 1'b1;
        #1;
        check("rst_data", {31'd0, joy_data}, 32'd1);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Fresh frame after reset: ~{3C1, A5C} = C3E5A3
        do_load(12'hA5C, 12'h3C1);
        run_edges("post_rst", 24, stream, done_edge, done_cnt);
        check("post_stream", stream, 32'hFFC3_E5A3);
        check("post_done_edge", done_edge, 24);
        check("post_done_cnt", done_cnt, 1);

        // Single-cycle high glitch on joy_clk
        do_load(12'h001, 12'h000);
        joy_clk = 1'b0;
        repeat (5) @(negedge clk);
        joy_clk = 1'b1;
        @(negedge clk);
        joy_clk = 1'b0;
        repeat (6) @(negedge clk);
`ifdef JTFRAME_DB15_TX_DEGLITCH_EN
        check("glitch_data", {31'd0, joy_data}, 32'd0);
`else
        check("glitch_data", {31'd0, joy_data}, 32'd1);
`endif
        $display("xfer glitch: joy_data=%b", joy_data);
        joy_clk = 1'b1;
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
